dcache_refill_unit: RTL and testbench

Miss-repair engine directly downstream of the data-cache controller's miss outputs. It detects a pending read or write miss and fetches the 1024-bit block from main memory as a burst of 64-bit beats. It assembles the block and returns it with a one-cycle `repair_resolved` pulse, which the controller uses to write the block and tag and to release its stall.

---
 rtl/dcache_refill_unit.sv | 161 ++++++++++++++++
 tb/tb_dcache_refill_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_refill_unit.sv
// ============================================================================
// dcache_refill_unit : data-cache miss refill engine (16 x 64-bit burst fill)
// Optional: DCACHE_REFILL_CWF_EN enables critical-word-first beat ordering.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dcache_refill_unit #(
   parameter int BLOCK_BITS = 1024,
   parameter int BEAT_BITS  = 64,
   parameter int ADDR_BITS  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  read_miss_repair,
   input  logic                  write_miss_repair,
   input  logic [ADDR_BITS-1:0]  missed_addr,
   output logic                  repair_resolved,
   output logic [BLOCK_BITS-1:0] fill_data,
   output logic [ADDR_BITS-1:0]  fill_addr,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_BITS-1:0]  mem_req_addr,
   input  logic                  mem_rsp_valid,
   input  logic [BEAT_BITS-1:0]  mem_rsp_data,
   input  logic                  mem_rsp_last,
   output logic                  busy,
   output logic                  err
);

   localparam int c_BEATS    = BLOCK_BITS / BEAT_BITS;
   localparam int c_CNT_W    = $clog2(c_BEATS);
   localparam int c_BLK_OFF  = $clog2(BLOCK_BITS / 8);
   localparam int c_BEAT_OFF = $clog2(BEAT_BITS / 8);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_FILL = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                         r_state;
   state_t                         w_next;
   logic [c_CNT_W-1:0]             r_cnt;
   logic [c_CNT_W-1:0]             w_slot;
   logic [ADDR_BITS-c_BLK_OFF-1:0] r_miss_blk;
   logic [BLOCK_BITS-1:0]          r_fill_data;
   logic [ADDR_BITS-1:0]           r_fill_addr;
   logic [ADDR_BITS-1:0]           r_req_addr;
   logic                           r_req_valid;
   logic                           r_resolved;
   logic                           r_busy;
   logic                           r_err;
   logic                           w_miss;
   logic                           w_beat;
   logic                           w_unused;

   assign w_miss   = read_miss_repair | write_miss_repair;
   assign w_beat   = (r_state == S_FILL) && mem_rsp_valid;
   assign w_unused = ^missed_addr[c_BLK_OFF-1:0];

`ifdef DCACHE_REFILL_CWF_EN
   logic [c_CNT_W-1:0] r_start;

   // Memory returns beats in wrap order starting at the missed word.
   assign w_slot = r_cnt + r_start;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_start <= '0;
      end else if (r_state == S_IDLE && w_miss) begin
         r_start <= missed_addr[c_BLK_OFF-1:c_BEAT_OFF];
      end
   end
`else
   assign w_slot = r_cnt;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_miss)                   w_next = S_REQ;
         S_REQ:  if (mem_req_ready)            w_next = S_FILL;
         S_FILL: if (w_beat && (r_cnt == '1))  w_next = S_DONE;
         S_DONE:                               w_next = S_IDLE;
         default:                              w_next = S_IDLE;
      endcase
   end

   // Status outputs are registered off the next state so they align with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_req_valid <= 1'b0;
         r_resolved  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_req_valid <= (w_next == S_REQ);
         r_resolved  <= (w_next == S_DONE);
         r_busy      <= (w_next != S_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_miss_blk  <= '0;
         r_req_addr  <= '0;
         r_fill_addr <= '0;
         r_fill_data <= '0;
         r_err       <= 1'b0;
      end else begin
         if (r_state == S_IDLE && w_miss) begin
            r_cnt      <= '0;
            r_miss_blk <= missed_addr[ADDR_BITS-1:c_BLK_OFF];
`ifdef DCACHE_REFILL_CWF_EN
            r_req_addr <= {missed_addr[ADDR_BITS-1:c_BEAT_OFF], {c_BEAT_OFF{1'b0}}};
`else
            r_req_addr <= {missed_addr[ADDR_BITS-1:c_BLK_OFF], {c_BLK_OFF{1'b0}}};
`endif
         end
         // The previous block stays visible until the new burst is accepted.
         if (r_state == S_REQ && mem_req_ready) begin
            r_fill_addr <= {r_miss_blk, {c_BLK_OFF{1'b0}}};
         end
         if (w_beat) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
            for (int i = 0; i < c_BEATS; i++) begin
               if (w_slot == c_CNT_W'(i)) begin
                  r_fill_data[i*BEAT_BITS +: BEAT_BITS] <= mem_rsp_data;
               end
            end
            if (mem_rsp_last != (r_cnt == '1)) begin
               r_err <= 1'b1;
            end
         end
         if (mem_rsp_valid && r_state != S_FILL) begin
            r_err <= 1'b1;
         end
      end
   end

   assign repair_resolved = r_resolved;
   assign fill_data       = r_fill_data;
   assign fill_addr       = r_fill_addr;
   assign mem_req_valid   = r_req_valid;
   assign mem_req_addr    = r_req_addr;
   assign busy            = r_busy;
   assign err             = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dcache_refill_unit.sv
// ============================================================================
// tb_dcache_refill_unit : directed self-checking bench for dcache_refill_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dcache_refill_unit;

`ifdef DCACHE_REFILL_CWF_EN
   localparam bit c_CWF = 1'b1;
`else
   localparam bit c_CWF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          read_miss_repair;
   logic          write_miss_repair;
   logic [31:0]   missed_addr;
   logic          repair_resolved;
   logic [1023:0] fill_data;
   logic [31:0]   fill_addr;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic [31:0]   mem_req_addr;
   logic          mem_rsp_valid;
   logic [63:0]   mem_rsp_data;
   logic          mem_rsp_last;
   logic          busy;
   logic          err;

   int            vecs = 0;
   int            errs = 0;
   logic [31:0]   prev_fill_addr = '0;

   always #5 clk = ~clk;

   dcache_refill_unit dut (
      .clk               (clk),
      .rst               (rst),
      .read_miss_repair  (read_miss_repair),
      .write_miss_repair (write_miss_repair),
      .missed_addr       (missed_addr),
      .repair_resolved   (repair_resolved),
      .fill_data         (fill_data),
      .fill_addr         (fill_addr),
      .mem_req_valid     (mem_req_valid),
      .mem_req_ready     (mem_req_ready),
      .mem_req_addr      (mem_req_addr),
      .mem_rsp_valid     (mem_rsp_valid),
      .mem_rsp_data      (mem_rsp_data),
      .mem_rsp_last      (mem_rsp_last),
      .busy              (busy),
      .err               (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pat(input logic [31:0] seed, input logic [3:0] slot);
      return {seed, 28'h0, slot};
   endfunction

   task automatic check_block(input string tag, input logic [31:0] seed, input bit zero);
      logic [63:0] exp;
      for (int i = 0; i < 16; i++) begin
         exp = zero ? 64'h0 : pat(seed, 4'(i));
         check($sformatf("%s slot%0d", tag, i), fill_data[i*64 +: 64], exp);
      end
   endtask

   // One complete miss: request (with optional ready stall), 16 beats
   // (optional idle gaps), resolution pulse, then the controller drops its flags.
   task automatic run_fill(input string tag, input logic [31:0] addr, input logic rd,
                           input logic wr, input int ready_wait, input int gap,
                           input int last_pos, input logic [31:0] seed,
                           input logic [31:0] exp_req);
      logic [3:0] s;
      logic [3:0] slot;
      s = c_CWF ? addr[6:3] : 4'd0;
      read_miss_repair  = rd;
      write_miss_repair = wr;
      missed_addr       = addr;
      mem_req_ready     = (ready_wait == 0);
      check({tag, " idle busy"}, 64'(busy), 64'd0);
      tick();
      check({tag, " req fill_addr held"}, 64'(fill_addr), 64'(prev_fill_addr));
      for (int i = 0; i < ready_wait; i++) begin
         check({tag, " req valid wait"}, 64'(mem_req_valid), 64'd1);
         check({tag, " req addr wait"}, 64'(mem_req_addr), 64'(exp_req));
         tick();
      end
      mem_req_ready = 1'b1;
      check({tag, " req valid"}, 64'(mem_req_valid), 64'd1);
      check({tag, " req addr"}, 64'(mem_req_addr), 64'(exp_req));
      check({tag, " busy"}, 64'(busy), 64'd1);
      tick();
      mem_req_ready = 1'b0;
      check({tag, " single req"}, 64'(mem_req_valid), 64'd0);
      for (int k = 0; k < 16; k++) begin
         if (k > 0) begin
            for (int g = 0; g < gap; g++) begin
               mem_rsp_valid = 1'b0;
               check({tag, " early resolve"}, 64'(repair_resolved), 64'd0);
               tick();
            end
         end
         slot          = s + 4'(k);
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = pat(seed, slot);
         mem_rsp_last  = (k == last_pos);
         check({tag, " early resolve"}, 64'(repair_resolved), 64'd0);
         tick();
      end
      mem_rsp_valid = 1'b0;
      mem_rsp_last  = 1'b0;
      check({tag, " resolved"}, 64'(repair_resolved), 64'd1);
      check({tag, " fill_addr"}, 64'(fill_addr), 64'({addr[31:7], 7'b0}));
      check_block({tag, " data"}, seed, 1'b0);
      read_miss_repair  = 1'b0;
      write_miss_repair = 1'b0;
      tick();
      check({tag, " pulse width"}, 64'(repair_resolved), 64'd0);
      check({tag, " back idle"}, 64'(busy), 64'd0);
      check({tag, " no req after"}, 64'(mem_req_valid), 64'd0);
      check({tag, " data hold"}, fill_data[63:0], pat(seed, 4'd0));
      prev_fill_addr = {addr[31:7], 7'b0};
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " resolved"}, 64'(repair_resolved), 64'd0);
      check({tag, " req_valid"}, 64'(mem_req_valid), 64'd0);
      check({tag, " busy"}, 64'(busy), 64'd0);
      check({tag, " err"}, 64'(err), 64'd0);
      check({tag, " fill_addr"}, 64'(fill_addr), 64'd0);
      check({tag, " req_addr"}, 64'(mem_req_addr), 64'd0);
      check_block({tag, " data"}, 32'h0, 1'b1);
   endtask

   initial begin
      rst               = 1'b1;
      read_miss_repair  = 1'b0;
      write_miss_repair = 1'b0;
      missed_addr       = '0;
      mem_req_ready     = 1'b0;
      mem_rsp_valid     = 1'b0;
      mem_rsp_data      = '0;
      mem_rsp_last      = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();
      check_all_zero("post reset");

      // Basic read miss: data = beat index, 18-cycle latency path
      run_fill("basic", 32'h0000_1284, 1'b1, 1'b0, 0, 0, 15, 32'h0, 32'h0000_1280);
      check("basic err", 64'(err), 64'd0);

      // Request stalled 5 cycles, beats separated by one idle cycle
      run_fill("stall", 32'h0000_ABC0, 1'b1, 1'b0, 5, 1, 15, 32'h11,
               c_CWF ? 32'h0000_ABC0 : 32'h0000_AB80);

      // Read and write flags together: one request, one resolution
      run_fill("both", 32'h2000_0300, 1'b1, 1'b1, 0, 0, 15, 32'h22, 32'h2000_0300);
      tick();
      check("both stays idle", 64'(busy), 64'd0);
      check("both no 2nd req", 64'(mem_req_valid), 64'd0);
      check("both err", 64'(err), 64'd0);

      // Stray beat in IDLE, then a fill with last on beat 7
      mem_rsp_valid = 1'b1;
      tick();
      mem_rsp_valid = 1'b0;
      check("stray err", 64'(err), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("err cleared", 64'(err), 64'd0);
      prev_fill_addr = '0;
      tick();
      run_fill("early last", 32'h0000_4000, 1'b1, 1'b0, 0, 0, 7, 32'h33, 32'h0000_4000);
      check("early last err", 64'(err), 64'd1);
      run_fill("sticky", 32'h0000_5008, 1'b0, 1'b1, 0, 0, 15, 32'h44,
               c_CWF ? 32'h0000_5008 : 32'h0000_5000);
      check("err sticky", 64'(err), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("err reset", 64'(err), 64'd0);
      prev_fill_addr = '0;
      tick();

      // Reset after beat 9 of a fill
      read_miss_repair = 1'b1;
      missed_addr      = 32'h0000_6000;
      mem_req_ready    = 1'b1;
      tick();
      tick();
      mem_req_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = pat(32'h99, 4'(k));
         tick();
      end
      mem_rsp_valid = 1'b0;
      check("midfill busy", 64'(busy), 64'd1);
      read_miss_repair = 1'b0;
      rst              = 1'b1;
      tick();
      rst = 1'b0;
      check_all_zero("midfill rst");
      tick();
      check("midfill stays idle", 64'(busy), 64'd0);
      prev_fill_addr = '0;
      run_fill("restart", 32'h0000_7000, 1'b1, 1'b0, 0, 0, 15, 32'h55, 32'h0000_7000);

      // Critical-word-first vector: start beat 13
      run_fill("cwf", 32'h1000_0068, 1'b1, 1'b0, 0, 0, 15, 32'h66,
               c_CWF ? 32'h1000_0068 : 32'h1000_0000);
      check("final err", 64'(err), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

`default_nettype wire
